mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//  Multi-cycle multiply/divide unit that owns the HI/LO registers and sits beside the EX stage.
//  It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO when the op leaves EX.
//  It drives isbusy to the hazard/stall unit, which holds IF/ID while isbusy && RHL_visit.
//  It supplies HI/LO to the MFHI/MFLO datapath.
// PARAMETERS
//  MUL_LAT  2  cycles isbusy stays high for MULT/MULTU (1..4); product is registered MUL_LAT times
//  DIV_ITER 32 radix-2 restoring iterations; fixed at 32, exposed for bench shortening only
// PORTS
//  clk         in   1   core clock
//  rst_n       in   1   asynchronous active-low reset
//  start_i     in   1   op valid; one-cycle pulse, already qualified with EX advancing
//  op_i        in   4   mdu_op_t (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO[, MADD ops])
//  rs_i        in   32  operand A (dividend / multiplicand / MTHI-MTLO data), post-bypass
//  rt_i        in   32  operand B (divisor / multiplier), post-bypass
//  cancel_i    in   1   MEM1 exception or eret flush; aborts an in-flight op
//  isbusy      out  1   operation in flight; HI/LO not yet final
//  hi_o        out  32  architectural HI
//  lo_o        out  32  architectural LO
// BEHAVIOUR
//  - Reset: FSM=IDLE, isbusy=0, hi_o=0, lo_o=0, counters=0.
//  - FSM states: IDLE -> MUL | DIV -> IDLE.
//  - MTHI/MTLO: write in the accept cycle; visible the next cycle; isbusy stays 0.
//  - MULT/MULTU:
//    - Latch operands at accept; enter MUL with cnt=MUL_LAT.
//    - isbusy=1 for MUL_LAT cycles.
//    - {HI,LO} = 64-bit product, signed or unsigned per op, written on the last MUL cycle.
//    - Result is visible when isbusy falls.
//  - DIV/DIVU:
//    - Accept cycle latches |A| and |B| (signed) or raw values, plus both sign bits; enter DIV with cnt=DIV_ITER.
//    - Each cycle: shift {rem,quo} left 1; if rem>=divisor, subtract and set quo[0].
//    - Last iteration also does the fix-up: negate quo if signs differ; negate rem if dividend<0.
//    - LO=quo, HI=rem.
//    - isbusy=1 for DIV_ITER cycles (32); then IDLE.
//  - Divide by zero (rt_i==0): run full latency; LO=32'hFFFF_FFFF, HI=rs_i; no exception raised.
//  - Signed overflow (0x8000_0000 / -1): LO=0x8000_0000, HI=0.
//  - start_i while isbusy: ignored. The stall unit guarantees this never occurs, and the bench asserts it.
//  - cancel_i:
//    - Aborts MUL/DIV at once; FSM returns to IDLE next cycle; isbusy=0 next cycle.
//    - HI/LO keep their pre-op values.
//    - cancel_i together with start_i: the start is dropped; MTHI/MTLO are not written.
//  - cancel_i on the cycle HI/LO would be written: cancel wins and there is no write.
//  - No partial HI/LO update is ever visible; HI and LO change in the same cycle.
// CONFIGURATION
//  - MDU_MADD_EN defined:
//    - op_i additionally decodes MADD, MADDU, MSUB, MSUBU.
//    - They use the MUL path plus one extra cycle: {HI,LO} +/- product, 64-bit wrap.
//    - isbusy is high for MUL_LAT+1 cycles.
//  - MDU_MADD_EN undefined: those encodings are treated as no-op; no HI/LO change; isbusy=0.
// STRUCTURE
//  - Shared package mdu_pkg holds:
//    - mdu_op_t enum (4-bit);
//    - mdu_state_t {IDLE, MUL, DIV};
//    - constants DIV_BY_ZERO_LO=32'hFFFF_FFFF and MUL_LAT_MAX=4.
//  - Sub-module mdu_div_iter holds the radix-2 restoring divider datapath (one iteration per cycle, with a sign fix-up step).
//  - Top-level mdu_hilo holds the FSM, the multiplier pipe and the HI/LO registers.
// TESTING
//  - MULT rs=-3 rt=7 -> isbusy high 2 cycles; then HI=FFFF_FFFF, LO=FFFF_FFEB.
//  - MULTU rs=FFFF_FFFF rt=FFFF_FFFF -> HI=FFFF_FFFE, LO=0000_0001.
//  - DIV rs=-7 rt=2 -> isbusy 32 cycles; LO=FFFF_FFFD, HI=FFFF_FFFF.
//  - DIVU rs=100 rt=0 -> LO=FFFF_FFFF, HI=100 after 32 cycles.
//  - DIV in flight, cancel_i at iteration 10 -> isbusy=0 next cycle; HI/LO equal pre-op values.
//  - MTLO 0x1234 -> LO=0x1234 next cycle, isbusy never set.
//  - MTLO with cancel_i -> LO unchanged.
//  - Reset asserted mid-DIV (rst_n=0) -> isbusy, hi_o and lo_o go to 0 asynchronously.
//  - With MDU_MADD_EN: HI:LO=0:5, MADD 3*4 -> HI=0, LO=17.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   mdu_op_t       : 4-bit operation code carried on op_i
//   mdu_state_t    : FSM state encoding, also exported on the debug port
//   DIV_BY_ZERO_LO : LO value produced by a divide by zero
//   MUL_LAT_MAX    : upper bound on the multiplier latency parameter
//   sext64         : sign- or zero-extends a 32-bit operand to 64 bits
// The MADD/MADDU/MSUB/MSUBU encodings are always defined here.
// Only the MDU_MADD_EN build of mdu_hilo executes them.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;
  localparam int          MUL_LAT_MAX    = 4;

  function automatic logic [63:0] sext64(input logic is_signed, input logic [31:0] v);
    return is_signed ? {{32{v[31]}}, v} : {32'b0, v};
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider datapath: one quotient bit per i_step cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : latch operands (magnitudes for signed, raw for unsigned)
//   i_step     : perform one shift/compare/subtract iteration
//   i_signed   : operands are two's complement (sampled with i_load)
//   i_a, i_b   : dividend, divisor (sampled with i_load)
//   o_quo      : quotient after the iteration in progress, sign-corrected
//   o_rem      : remainder after the iteration in progress, sign-corrected
// o_quo/o_rem are combinational from the current iteration.
// The caller captures them on the final iteration.
// This folds the sign fix-up into that last cycle.
module mdu_div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dbz;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_sh;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_rem_n;
  logic [31:0] w_quo_n;

  assign w_a_neg = i_signed & i_a[31];
  assign w_b_neg = i_signed & i_b[31];
  assign w_a_abs = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_b_abs = w_b_neg ? (32'd0 - i_b) : i_b;

  // Partial remainder shifted left with the next dividend bit.
  // Needs 33 bits because it can reach 2*divisor-1.
  assign w_sh    = {r_rem, r_quo[31]};
  assign w_ge    = (w_sh >= {1'b0, r_div});
  // When w_ge holds, the true difference is below the divisor.
  // So a 32-bit subtraction is exact.
  assign w_diff  = w_sh[31:0] - r_div;
  assign w_rem_n = w_ge ? w_diff : w_sh[31:0];
  assign w_quo_n = {r_quo[30:0], w_ge};

  // A zero divisor yields all-ones quotient bits and remainder |A|.
  // The remainder sign fix-up then restores rs, so only LO needs overriding.
  assign o_quo = r_dbz   ? DIV_BY_ZERO_LO :
                 r_neg_q ? (32'd0 - w_quo_n) : w_quo_n;
  assign o_rem = r_neg_r ? (32'd0 - w_rem_n) : w_rem_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (i_load) begin
      r_rem   <= '0;
      r_quo   <= w_a_abs;
      r_div   <= w_b_abs;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dbz   <= (i_b == 32'd0);
    end else if (i_step) begin
      r_rem   <= w_rem_n;
      r_quo   <= w_quo_n;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : one-cycle op pulse (already qualified with EX advancing)
//   op_i        : mdu_op_t encoding
//   rs_i, rt_i  : operands A and B (post-bypass)
//   cancel_i    : flush; aborts an in-flight op and drops a same-cycle start
//   isbusy      : operation in flight, HI/LO not yet final
//   hi_o, lo_o  : architectural HI and LO
//   dbg_state_o : current FSM state
// Optional feature macro: MDU_MADD_EN.
// When defined, MADD/MADDU/MSUB/MSUBU accumulate into {HI,LO}.
// When undefined, those encodings are no-ops.
//
// Handshake: start_i is accepted only in IDLE when cancel_i is low.
// MTHI/MTLO commit on the accept edge and never raise isbusy.
// MUL/DIV ops raise isbusy from the accept edge until the edge that writes HI/LO.
// HI and LO become visible in the same cycle that isbusy falls.
// A start_i seen while isbusy is high is ignored.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        cancel_i,
  output logic        isbusy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output mdu_state_t  dbg_state_o
);

  localparam int MUL_LAT_C = (MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX :
                             (MUL_LAT < 1)           ? 1 : MUL_LAT;
  // The operand latch is the first stage; PIPE_N product stages follow it.
  localparam int PIPE_N    = (MUL_LAT_C > 1) ? MUL_LAT_C - 1 : 1;
  localparam logic [5:0] CNT_MUL = 6'(MUL_LAT_C);
  localparam logic [5:0] CNT_DIV = 6'(DIV_ITER);

  mdu_state_t  r_state;
  mdu_state_t  w_state_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_hilo_we;
  logic [31:0] w_hi_d;
  logic [31:0] w_lo_d;

  mdu_op_t     w_op;
  logic        w_mul_load;
  logic        w_div_load;
  logic        w_div_step;
  logic [31:0] w_div_quo;
  logic [31:0] w_div_rem;

  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic        r_mul_signed;
  logic [63:0] r_pipe [PIPE_N];
  logic [63:0] w_prod;
  logic [63:0] w_pipe_out;

`ifdef MDU_MADD_EN
  logic        r_is_acc;
  logic        r_acc_sub;
  logic [63:0] r_acc_prod;
`endif

  assign w_op        = mdu_op_t'(op_i);
  assign isbusy      = (r_state != IDLE);
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;
  assign dbg_state_o = r_state;

  // The low 64 bits of the extended product are correct for both signednesses.
  assign w_prod = sext64(r_mul_signed, r_mul_a) * sext64(r_mul_signed, r_mul_b);

  generate
    if (MUL_LAT_C > 1) begin : g_pipe_out
      assign w_pipe_out = r_pipe[PIPE_N-1];
    end else begin : g_comb_out
      assign w_pipe_out = w_prod;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hilo_we   = 1'b0;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    w_mul_load  = 1'b0;
    w_div_load  = 1'b0;
    w_div_step  = 1'b0;
    if (cancel_i) begin
      // Flush beats everything, including the final write cycle.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            case (w_op)
              MDU_MULT, MDU_MULTU: begin
                w_mul_load  = 1'b1;
                w_state_nxt = MUL;
                w_cnt_nxt   = CNT_MUL;
              end
`ifdef MDU_MADD_EN
              MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
                w_mul_load  = 1'b1;
                w_state_nxt = MUL;
                w_cnt_nxt   = CNT_MUL + 6'd1;
              end
`endif
              MDU_DIV, MDU_DIVU: begin
                w_div_load  = 1'b1;
                w_state_nxt = DIV;
                w_cnt_nxt   = CNT_DIV;
              end
              MDU_MTHI: begin
                w_hilo_we = 1'b1;
                w_hi_d    = rs_i;
              end
              MDU_MTLO: begin
                w_hilo_we = 1'b1;
                w_lo_d    = rs_i;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          w_cnt_nxt = r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            w_hilo_we   = 1'b1;
            w_state_nxt = IDLE;
`ifdef MDU_MADD_EN
            if (r_is_acc) begin
              {w_hi_d, w_lo_d} = r_acc_sub ? ({r_hi, r_lo} - r_acc_prod)
                                           : ({r_hi, r_lo} + r_acc_prod);
            end else begin
              {w_hi_d, w_lo_d} = w_pipe_out;
            end
`else
            {w_hi_d, w_lo_d} = w_pipe_out;
`endif
          end
        end
        DIV: begin
          w_div_step = 1'b1;
          w_cnt_nxt  = r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            w_hilo_we   = 1'b1;
            w_hi_d      = w_div_rem;
            w_lo_d      = w_div_quo;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_hilo_we) begin
        r_hi <= w_hi_d;
        r_lo <= w_lo_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_signed <= 1'b0;
    end else if (w_mul_load) begin
      r_mul_a      <= rs_i;
      r_mul_b      <= rt_i;
      r_mul_signed <= (w_op == MDU_MULT) || (w_op == MDU_MADD) || (w_op == MDU_MSUB);
    end
  end

  // Operands stay frozen for the whole op, so the pipe runs without enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_N; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < PIPE_N; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

`ifdef MDU_MADD_EN
  // Extra stage for accumulate ops.
  // On the final cycle it holds the product that was ready one cycle earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_acc   <= 1'b0;
      r_acc_sub  <= 1'b0;
      r_acc_prod <= '0;
    end else begin
      r_acc_prod <= w_pipe_out;
      if (w_mul_load) begin
        r_is_acc  <= (w_op == MDU_MADD) || (w_op == MDU_MADDU) ||
                     (w_op == MDU_MSUB) || (w_op == MDU_MSUBU);
        r_acc_sub <= (w_op == MDU_MSUB) || (w_op == MDU_MSUBU);
      end
    end
  end
`endif

  mdu_div_iter u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_div_load),
    .i_step   (w_div_step),
    .i_signed (w_op == MDU_DIV),
    .i_a      (rs_i),
    .i_b      (rt_i),
    .o_quo    (w_div_quo),
    .o_rem    (w_div_rem)
  );

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo.
// Busy ops push {HI,LO} and the busy length when driven.
// A monitor pops them when isbusy falls.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int MUL_LAT  = 2;
  localparam int DIV_ITER = 32;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0;
  logic        cancel_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] rs_i = '0;
  logic [31:0] rt_i = '0;
  logic        isbusy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  mdu_state_t  dbg_state;

  always #5 clk = ~clk;

  mdu_hilo #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .cancel_i    (cancel_i),
    .isbusy      (isbusy),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  string       tag_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          busy_cnt = 0;
  logic [63:0] mon_exp;
  int          mon_lat;
  string       mon_tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (isbusy === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_lat = lat_q.pop_front();
        mon_tag = tag_q.pop_front();
        chk({mon_tag, "_hilo"}, {hi_o, lo_o}, mon_exp);
        chk({mon_tag, "_busy"}, 64'(busy_cnt), 64'(mon_lat));
      end
      busy_cnt = 0;
    end
  end

  // reference model
  function automatic logic [63:0] mul_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    if (s) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end
    u = {32'b0, a} * {32'b0, b};
    return u;
  endfunction

  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int q;
    int r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // driver tasks
  task automatic drive_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic cancel);
    @(posedge clk); #1;
    chk("idle_before_start", 64'(isbusy), 64'd0);
    start_i = 1'b1; op_i = op; rs_i = a; rt_i = b; cancel_i = cancel;
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (isbusy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 64'(isbusy), 64'd0);
  endtask

  task automatic do_busy(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    exp_q.push_back(exp); lat_q.push_back(lat); tag_q.push_back(tag);
    drive_start(op, a, b, 1'b0);
    wait_idle();
    {m_hi, m_lo} = exp;
  endtask

  task automatic do_mt(input string tag, input logic [3:0] op, input logic [31:0] d,
                       input logic cancel);
    drive_start(op, d, 32'd0, cancel);
    if (!cancel) begin
      if (op == MDU_MTHI) m_hi = d;
      else                m_lo = d;
    end
    chk({tag, "_busy"}, 64'(isbusy), 64'd0);
    chk({tag, "_hilo"}, {hi_o, lo_o}, {m_hi, m_lo});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          k;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 64'(isbusy), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    do_busy("mult_m3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, MUL_LAT);
    do_busy("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, MUL_LAT);
    do_busy("div_m7d2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_ITER);
    do_busy("divu_dbz", MDU_DIVU, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, DIV_ITER);
    do_busy("div_dbz_neg", MDU_DIV, 32'hFFFF_FF9C, 32'd0, {32'hFFFF_FF9C, 32'hFFFF_FFFF}, DIV_ITER);
    do_busy("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_ITER);
    do_busy("divu_big", MDU_DIVU, 32'hFFFF_FFFF, 32'd10, {32'd5, 32'h1999_9999}, DIV_ITER);

    do_mt("mtlo", MDU_MTLO, 32'h0000_1234, 1'b0);
    do_mt("mthi", MDU_MTHI, 32'hCAFE_0001, 1'b0);
    do_mt("mtlo_cancel", MDU_MTLO, 32'hDEAD_BEEF, 1'b1);

    // DIV cancelled during its 10th busy cycle: HI/LO keep pre-op values.
    exp_q.push_back({m_hi, m_lo}); lat_q.push_back(10); tag_q.push_back("div_cancel");
    drive_start(MDU_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 cancel_i = 1'b1;
    @(posedge clk); #1 cancel_i = 1'b0;
    wait_idle();

    // MULT cancelled on its write cycle: no write.
    exp_q.push_back({m_hi, m_lo}); lat_q.push_back(MUL_LAT); tag_q.push_back("mul_cancel_last");
    drive_start(MDU_MULT, 32'd5, 32'd6, 1'b0);
    repeat (MUL_LAT - 1) @(posedge clk);
    #1 cancel_i = 1'b1;
    @(posedge clk); #1 cancel_i = 1'b0;
    wait_idle();

`ifdef MDU_MADD_EN
    do_mt("madd_sethi", MDU_MTHI, 32'd0, 1'b0);
    do_mt("madd_setlo", MDU_MTLO, 32'd5, 1'b0);
    do_busy("madd_3x4", MDU_MADD, 32'd3, 32'd4, {32'd0, 32'd17}, MUL_LAT + 1);
`else
    drive_start(MDU_MADD, 32'd3, 32'd4, 1'b0);
    chk("madd_noop_busy", 64'(isbusy), 64'd0);
    chk("madd_noop_hilo", {hi_o, lo_o}, {m_hi, m_lo});
`endif

    for (int i = 0; i < 10; i++) begin
      a = $urandom();
      b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom();
      k = $urandom_range(0, 3);
      case (k)
        0: do_busy("rnd_mult", MDU_MULT, a, b, mul_model(1'b1, a, b), MUL_LAT);
        1: do_busy("rnd_multu", MDU_MULTU, a, b, mul_model(1'b0, a, b), MUL_LAT);
        2: do_busy("rnd_div", MDU_DIV, a, b, div_model(1'b1, a, b), DIV_ITER);
        default: do_busy("rnd_divu", MDU_DIVU, a, b, div_model(1'b0, a, b), DIV_ITER);
      endcase
    end

    // Reset mid-DIV: outputs clear asynchronously.
    do_mt("pre_rst_lo", MDU_MTLO, 32'h5555_AAAA, 1'b0);
    exp_q.push_back(64'd0); lat_q.push_back(4); tag_q.push_back("div_reset");
    drive_start(MDU_DIV, 32'd77, 32'd3, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(isbusy), 64'd0);
    chk("async_rst_hilo", {hi_o, lo_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    do_mt("post_rst_lo", MDU_MTLO, 32'h0000_00A5, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
